// File: rtl/pkt_field_extract.sv
// Byte-serial packet parser: decodes the type byte, assembles big-endian 16-bit
// fields into shadow registers and commits them to the outputs with en_MNI.
module pkt_field_extract #(
    parameter int BYTE_WIDTH = 8,
    parameter int WORD_WIDTH = 16
) (
    input  logic                  clk,
    input  logic                  nrst,
    input  logic [BYTE_WIDTH-1:0] in_data,
    input  logic                  in_valid,
    input  logic                  in_sop,
    output logic                  in_ready,
    output logic                  en_MNI,
    output logic [2:0]            fPktType,
    output logic [WORD_WIDTH-1:0] hops,
    output logic [WORD_WIDTH-1:0] e_max,
    output logic [WORD_WIDTH-1:0] e_min,
    output logic [WORD_WIDTH-1:0] e_threshold,
    output logic [WORD_WIDTH-1:0] ch_ID,
    output logic [WORD_WIDTH-1:0] timeslot,
    output logic [WORD_WIDTH-1:0] src_ID,
    output logic                  pkt_err
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_HI,
        S_LO,
        S_COMMIT,
        S_DROP
    } state_t;

    localparam logic [2:0] T_HB   = 3'b000;
    localparam logic [2:0] T_CH   = 3'b001;
    localparam logic [2:0] T_SLOT = 3'b100;
    localparam logic [2:0] T_DATA = 3'b101;

    state_t                  state_q;
    logic [2:0]              type_q;
    logic [1:0]              word_cnt_q;
    logic [BYTE_WIDTH-1:0]   hi_q;
    logic [WORD_WIDTH-1:0]   shadow_q [4];
    logic                    en_mni_q;
    logic                    pkt_err_q;
    logic [2:0]              ftype_q;
    logic [WORD_WIDTH-1:0]   hops_q, e_max_q, e_min_q, e_thr_q;
    logic [WORD_WIDTH-1:0]   ch_id_q, timeslot_q, src_id_q;

    logic                    accept;
    logic                    sop_accept;
    logic                    type_ok;
    logic [1:0]              last_cnt;
    logic [WORD_WIDTH-1:0]   word_d;
    state_t                  start_state_d;

    assign in_ready   = (state_q != S_COMMIT);
    assign accept     = in_valid && in_ready;
    assign sop_accept = accept && in_sop;
    assign type_ok    = (in_data[BYTE_WIDTH-1:3] == '0) &&
                        (in_data[2:0] inside {T_HB, T_CH, T_SLOT, T_DATA});
    assign start_state_d = type_ok ? S_HI : S_DROP;
    assign last_cnt   = (type_q == T_HB) ? 2'd3 : 2'd0;
    assign word_d     = {hi_q, in_data};

    // The final word is committed straight from the incoming byte so that the
    // outputs and en_MNI appear in the cycle right after the last byte.
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            state_q    <= S_IDLE;
            type_q     <= '0;
            word_cnt_q <= '0;
            hi_q       <= '0;
            // NOTE: the shadow array is only four words, so it is cleared on
            // reset like any other register rather than left uninitialised.
            for (int i = 0; i < 4; i++) shadow_q[i] <= '0;
            en_mni_q   <= 1'b0;
            pkt_err_q  <= 1'b0;
            ftype_q    <= '0;
            hops_q     <= '0;
            e_max_q    <= '0;
            e_min_q    <= '0;
            e_thr_q    <= '0;
            ch_id_q    <= '0;
            timeslot_q <= '0;
            src_id_q   <= '0;
        end else begin
            // NOTE: pulse outputs default low each cycle; non-blocking keeps
            // every read in this block on the pre-edge values.
            en_mni_q  <= 1'b0;
            pkt_err_q <= 1'b0;
            if (sop_accept) begin
                pkt_err_q  <= (state_q == S_HI) || (state_q == S_LO);
                type_q     <= in_data[2:0];
                word_cnt_q <= '0;
                state_q    <= start_state_d;
            end else begin
                case (state_q)
                    S_HI: if (accept) begin
                        hi_q    <= in_data;
                        state_q <= S_LO;
                    end
                    S_LO: if (accept) begin
                        shadow_q[word_cnt_q] <= word_d;
                        if (word_cnt_q == last_cnt) begin
                            en_mni_q <= 1'b1;
                            ftype_q  <= type_q;
                            state_q  <= S_COMMIT;
                            case (type_q)
                                T_HB: begin
                                    hops_q  <= shadow_q[0];
                                    e_max_q <= shadow_q[1];
                                    e_min_q <= shadow_q[2];
                                    e_thr_q <= word_d;
                                end
                                T_CH:    ch_id_q    <= word_d;
                                T_SLOT:  timeslot_q <= word_d;
                                default: src_id_q   <= word_d;
                            endcase
                        end else begin
                            word_cnt_q <= word_cnt_q + 2'd1;
                            state_q    <= S_HI;
                        end
                    end
                    S_COMMIT: state_q <= S_IDLE;
                    default: ;
                endcase
            end
        end
    end

    assign en_MNI      = en_mni_q;
    assign pkt_err     = pkt_err_q;
    assign fPktType    = ftype_q;
    assign hops        = hops_q;
    assign e_max       = e_max_q;
    assign e_min       = e_min_q;
    assign e_threshold = e_thr_q;
    assign ch_ID       = ch_id_q;
    assign timeslot    = timeslot_q;
    assign src_ID      = src_id_q;

endmodule

// File: tb/tb_pkt_field_extract.sv
// Directed-vector bench for pkt_field_extract with hand-computed expectations.
module tb_pkt_field_extract;

    logic        clk = 1'b0;
    logic        nrst = 1'b0;
    logic [7:0]  in_data = '0;
    logic        in_valid = 1'b0;
    logic        in_sop = 1'b0;
    logic        in_ready, en_MNI, pkt_err;
    logic [2:0]  fPktType;
    logic [15:0] hops, e_max, e_min, e_threshold, ch_ID, timeslot, src_ID;

    int n_checks = 0;
    int n_errors = 0;
    int en_cnt   = 0;
    int err_cnt  = 0;
    int en_base, err_base;

    pkt_field_extract dut (
        .clk(clk), .nrst(nrst), .in_data(in_data), .in_valid(in_valid),
        .in_sop(in_sop), .in_ready(in_ready), .en_MNI(en_MNI),
        .fPktType(fPktType), .hops(hops), .e_max(e_max), .e_min(e_min),
        .e_threshold(e_threshold), .ch_ID(ch_ID), .timeslot(timeslot),
        .src_ID(src_ID), .pkt_err(pkt_err)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (nrst) begin
            if (en_MNI)  en_cnt++;
            if (pkt_err) err_cnt++;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Present one byte and hold it until the DUT accepts it; returns at edge+1.
    task automatic send(input logic [7:0] d, input logic sop);
        int   n;
        logic rdy;
        n = 0;
        in_data  = d;
        in_sop   = sop;
        in_valid = 1'b1;
        do begin
            rdy = in_ready;
            @(posedge clk);
            #1;
            n++;
        end while (!rdy && n < 10);
        if (!rdy) check("accept_timeout", 32'd0, 32'd1);
    endtask

    task automatic stop_valid();
        in_valid = 1'b0;
        in_sop   = 1'b0;
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        step(2);
        check("rst_hops", hops, 0);
        check("rst_type", fPktType, 0);
        check("rst_en", en_MNI, 0);
        nrst = 1'b1;
        step(1);
        check("rst_ready", in_ready, 1);
        check("rst_ch", ch_ID, 0);

        // HB packet with continuous valid
        send(8'h00, 1);
        send(8'h00, 0); send(8'h03, 0); send(8'h01, 0); send(8'hF4, 0);
        send(8'h00, 0); send(8'h64, 0); send(8'h00, 0); send(8'h32, 0);
        stop_valid();
        check("hb_en", en_MNI, 1);
        check("hb_ready_low", in_ready, 0);
        check("hb_type", fPktType, 3'b000);
        check("hb_hops", hops, 16'h0003);
        check("hb_emax", e_max, 16'h01F4);
        check("hb_emin", e_min, 16'h0064);
        check("hb_ethr", e_threshold, 16'h0032);
        step(1);
        check("hb_en_drop", en_MNI, 0);
        check("hb_ready_back", in_ready, 1);
        check("hb_en_count", en_cnt, 1);

        // CH packet after HB
        send(8'h01, 1); send(8'h00, 0); send(8'h0C, 0);
        stop_valid();
        check("ch_en", en_MNI, 1);
        check("ch_id", ch_ID, 16'h000C);
        check("ch_type", fPktType, 3'b001);
        check("ch_hops_hold", hops, 16'h0003);
        check("ch_emax_hold", e_max, 16'h01F4);
        step(1);

        // Slot packet with a 3-cycle gap between field bytes
        en_base = en_cnt;
        send(8'h04, 1); send(8'h12, 0);
        stop_valid();
        step(3);
        check("slot_gap_ts", timeslot, 16'h0000);
        check("slot_gap_en", en_cnt - en_base, 0);
        check("slot_gap_type", fPktType, 3'b001);
        send(8'h34, 0);
        stop_valid();
        check("slot_ts", timeslot, 16'h1234);
        check("slot_type", fPktType, 3'b100);
        step(1);
        check("slot_en_count", en_cnt - en_base, 1);

        // Truncated HB followed by data packet
        en_base = en_cnt; err_base = err_cnt;
        send(8'h00, 1); send(8'h00, 0); send(8'h05, 0);
        send(8'h05, 1);
        check("trunc_err_pulse", pkt_err, 1);
        send(8'h00, 0); send(8'h0C, 0);
        stop_valid();
        check("trunc_err_clear", pkt_err, 0);
        check("data_src", src_ID, 16'h000C);
        check("data_type", fPktType, 3'b101);
        check("trunc_hops_hold", hops, 16'h0003);
        step(1);
        check("trunc_err_count", err_cnt - err_base, 1);
        check("trunc_en_count", en_cnt - en_base, 1);

        // Unsupported type is dropped silently
        en_base = en_cnt; err_base = err_cnt;
        send(8'h02, 1);
        send(8'h11, 0); send(8'h22, 0); send(8'h33, 0); send(8'h44, 0);
        check("unsup_no_en", en_cnt - en_base, 0);
        send(8'h01, 1); send(8'hAB, 0); send(8'hCD, 0);
        stop_valid();
        check("unsup_ch_id", ch_ID, 16'hABCD);
        check("unsup_type", fPktType, 3'b001);
        step(1);
        check("unsup_en_count", en_cnt - en_base, 1);
        check("unsup_err_count", err_cnt - err_base, 0);

        // Reset in the middle of an HB packet
        send(8'h00, 1); send(8'h00, 0); send(8'h07, 0); send(8'h01, 0);
        stop_valid();
        nrst = 1'b0;
        #2;
        check("mid_rst_hops", hops, 0);
        check("mid_rst_ch", ch_ID, 0);
        check("mid_rst_src", src_ID, 0);
        check("mid_rst_type", fPktType, 0);
        step(2);
        nrst = 1'b1;
        step(1);
        en_base = en_cnt;
        send(8'h00, 0); send(8'h09, 0); send(8'h00, 0); send(8'h08, 0);
        stop_valid();
        step(2);
        check("post_rst_ignore_en", en_cnt - en_base, 0);
        check("post_rst_ignore_hops", hops, 0);
        send(8'h00, 1);
        send(8'h00, 0); send(8'h0A, 0); send(8'h00, 0); send(8'h0B, 0);
        send(8'h00, 0); send(8'h0C, 0); send(8'h00, 0); send(8'h0D, 0);
        stop_valid();
        check("post_rst_en", en_MNI, 1);
        check("post_rst_hops", hops, 16'h000A);
        check("post_rst_emax", e_max, 16'h000B);
        check("post_rst_emin", e_min, 16'h000C);
        check("post_rst_ethr", e_threshold, 16'h000D);
        check("post_rst_ch_hold", ch_ID, 0);
        step(2);
        check("post_rst_en_count", en_cnt - en_base, 1);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/pkt_field_extract.md
Name: pkt_field_extract

Overview:
- Byte-serial receive-side parser that sits directly upstream of the node-information register block.
- Accepts packet bytes from the radio RX buffer over a valid/ready handshake and decodes the packet type.
- Assembles the big-endian 16-bit fields for that type, then commits them all at once with a single-cycle en_MNI strobe.
- Outputs are shadow-buffered, so downstream never sees a half-updated field set.

Parameters:
BYTE_WIDTH, 8, width of in_data; fixed at 8.
WORD_WIDTH, 16, width of every extracted field; must equal 2*BYTE_WIDTH.

Ports:
clk  input  1  system clock
nrst  input  1  reset, asynchronous, active-low
in_data  input  8  packet byte
in_valid  input  1  in_data valid
in_sop  input  1  marks first (type) byte of a packet; meaningful only with in_valid
in_ready  output  1  block accepts the byte this cycle
en_MNI  output  1  one-cycle commit strobe
fPktType  output  3  committed packet type
hops  output  16  committed hop count (HB)
e_max  output  16  committed max energy (HB)
e_min  output  16  committed min energy (HB)
e_threshold  output  16  committed energy threshold (HB)
ch_ID  output  16  committed cluster-head ID (CH announce)
timeslot  output  16  committed TDMA slot (schedule)
src_ID  output  16  committed source ID (data)
pkt_err  output  1  one-cycle pulse on truncated packet

Behaviour:
- Byte transfer: a byte is accepted when in_valid && in_ready at a rising clk edge.
- in_ready = 0 only in state COMMIT; otherwise 1.
- Type byte: bits[2:0] = type; bits[7:3] must be 0.
- Word count per type: 000 HB = 4 words, in order hops, e_max, e_min, e_threshold. 001 CH = 1 word (ch_ID). 100 slot = 1 word (timeslot). 101 data = 1 word (src_ID).
- Any other type, or nonzero bits[7:3], is unsupported.
- Word assembly: first byte goes to [15:8], second byte to [7:0].
- FSM states:
  - IDLE: accepted byte with in_sop -> capture type. Supported -> HI with word_cnt = 0. Unsupported -> DROP. Accepted byte without in_sop -> discarded, stay IDLE.
  - HI: accepted byte without sop -> store high byte, go to LO.
  - LO: accepted byte without sop -> write the shadow field selected by word_cnt. If word_cnt == last, go to COMMIT; else word_cnt++ and go to HI.
  - COMMIT (exactly 1 cycle): copy shadow fields for the captured type into output registers and load fPktType. en_MNI = 1, in_ready = 0. Next state IDLE.
  - DROP: discard bytes until an accepted byte with in_sop, which is handled exactly like a sop byte in IDLE in that same cycle. No en_MNI, no pkt_err.
- Truncation: an accepted sop byte while in HI or LO causes:
  - pkt_err pulses 1 cycle (registered, next cycle);
  - the partial shadow is discarded and nothing is committed;
  - the sop byte is processed as a new type byte in the same cycle.
- Gaps: in_valid low in any state -> hold state and data.
- Latency: last field byte accepted at edge N -> outputs updated and en_MNI = 1 during cycle N+1. A new sop may be accepted from cycle N+2.
- Commit scope: only the fields of the committed type change. All other field outputs hold their previous values. fPktType holds between commits.
- Outputs are registered, and en_MNI/pkt_err are registered pulses.
- Reset: asynchronous on nrst low. FSM -> IDLE, word_cnt = 0, shadows = 0. All field outputs = 0, fPktType = 0, en_MNI = 0, pkt_err = 0. in_ready = 1 from the first cycle after reset release.
- Reset mid-packet: the partial packet is lost with no commit; the next packet needs a fresh sop.
- No arithmetic beyond the 2-bit word counter (max 3).

Test Plan:
- HB packet, sop byte 0x00 then 00 03 01 F4 00 64 00 32, continuous valid -> one cycle after the last byte: en_MNI = 1 for 1 cycle, fPktType = 000, hops = 0x0003, e_max = 0x01F4, e_min = 0x0064, e_threshold = 0x0032. in_ready = 0 that cycle only.
- CH packet 0x01, 00 0C after the HB packet -> ch_ID = 0x000C, fPktType = 001, en_MNI pulse. hops/e_* still hold the HB values.
- Slot packet 0x04, 12 34 with in_valid low for 3 cycles between bytes -> timeslot = 0x1234, one en_MNI. No change during the gaps.
- Truncation: 0x00, 00 05, then sop 0x05, 00 0C -> pkt_err pulse once. No HB commit, hops unchanged. Then src_ID = 0x000C, fPktType = 101, en_MNI once.
- Unsupported type 0x02 followed by 4 bytes, then sop 0x01 AB CD -> no en_MNI and no pkt_err for the 0x02 packet. ch_ID = 0xABCD committed.
- nrst pulsed low mid-HB after 3 field bytes -> all outputs 0 immediately. Non-sop bytes after release are ignored. A full HB afterwards commits correctly.
